// File: rtl/spectro_pkg.sv
// Shared spectrogram constants and FFT sequencing state, used by the
// frame scheduler, the FFT engine and the display.
package spectro_pkg;

   localparam int DATA_W    = 18;
   localparam int FRAME_LEN = 256;
   localparam int ADDR_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } fft_state_t;

endpackage

// File: rtl/sched_fill_ctr.sv
// Frame RAM fill counter: write index within the current bank, bank select,
// clear on capture disable and a last-slot flag for frame completion.
module sched_fill_ctr
   import spectro_pkg::*;
#(
   parameter int FRAME_LEN = spectro_pkg::FRAME_LEN,
   parameter int ADDR_W    = spectro_pkg::ADDR_W
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_wr,
   input  logic              i_swap,
   output logic [ADDR_W-1:0] o_wr_idx,
   output logic              o_wr_bank,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_wr_idx;
   logic              r_wr_bank;

   // Index wraps by width on the last slot; the bank only flips when the scheduler accepts the frame
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_idx  <= '0;
         r_wr_bank <= 1'b0;
      end else if (!i_en) begin
         r_wr_idx  <= '0;
      end else if (i_wr) begin
         r_wr_idx <= r_wr_idx + 1'b1;
         if (o_last && i_swap) begin
            r_wr_bank <= ~r_wr_bank;
         end
      end
   end

   assign o_wr_idx  = r_wr_idx;
   assign o_wr_bank = r_wr_bank;
   assign o_last    = (r_wr_idx == ADDR_W'(FRAME_LEN - 1));

endmodule

// File: rtl/spectro_frame_sched.sv
// Ping-pong frame scheduler between the mic decimator and the FFT engine.
// Define SCHED_OVERRUN_CNT_EN to add the saturating ovr_cnt dropped-frame counter.
module spectro_frame_sched
   import spectro_pkg::*;
#(
   parameter int DATA_W    = spectro_pkg::DATA_W,
   parameter int FRAME_LEN = spectro_pkg::FRAME_LEN,
   parameter int ADDR_W    = spectro_pkg::ADDR_W
)
(
   input  logic              CLK,
   input  logic              nRST,
   input  logic              EN,
   input  logic [DATA_W-1:0] ADATA,
   input  logic              ADATARDY,
   output logic              buf_we,
   output logic [ADDR_W:0]   buf_waddr,
   output logic [DATA_W-1:0] buf_wdata,
   output logic              fft_start,
   output logic              fft_bank,
   input  logic              fft_done,
   output logic              col_adv,
   output logic              overrun,
   output logic [15:0]       frame_cnt
`ifdef SCHED_OVERRUN_CNT_EN
   ,
   output logic [7:0]        ovr_cnt
`endif
);

   fft_state_t        r_state;
   fft_state_t        w_state_nxt;
   logic              r_pending;
   logic              r_pend_bank;
   logic              r_buf_we;
   logic [ADDR_W:0]   r_buf_waddr;
   logic [DATA_W-1:0] r_buf_wdata;
   logic              r_fft_start;
   logic              r_fft_bank;
   logic              r_col_adv;
   logic              r_overrun;
   logic [15:0]       r_frame_cnt;
   logic [ADDR_W-1:0] w_wr_idx;
   logic              w_wr_bank;
   logic              w_last;
   logic              w_wr;
   logic              w_done_run;
   logic              w_complete;
   logic              w_swap;
   logic              w_ovr;

   assign w_wr       = ADATARDY & EN;
   assign w_done_run = (r_state == RUN) & fft_done;
   assign w_complete = w_wr & w_last;
   // A completion in the same cycle as the FFT finishing counts as idle, so the swap wins
   assign w_swap     = w_complete & ((r_state == IDLE) | w_done_run);
   assign w_ovr      = w_complete & ~w_swap;

   sched_fill_ctr #(
      .FRAME_LEN (FRAME_LEN),
      .ADDR_W    (ADDR_W)
   ) u_fill_ctr (
      .i_clk     (CLK),
      .i_rst_n   (nRST),
      .i_en      (EN),
      .i_wr      (w_wr),
      .i_swap    (w_swap),
      .o_wr_idx  (w_wr_idx),
      .o_wr_bank (w_wr_bank),
      .o_last    (w_last)
   );

   // FFT sequencing state register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FFT sequencing next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (r_pending) w_state_nxt = START; else w_state_nxt = IDLE;
         START:   w_state_nxt = RUN;
         RUN:     if (fft_done) w_state_nxt = IDLE; else w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered RAM write port, FFT handshake, display strobe and frame bookkeeping
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pending   <= 1'b0;
         r_pend_bank <= 1'b0;
         r_buf_we    <= 1'b0;
         r_buf_waddr <= '0;
         r_buf_wdata <= '0;
         r_fft_start <= 1'b0;
         r_fft_bank  <= 1'b0;
         r_col_adv   <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_cnt <= 16'h0000;
      end else begin
         r_buf_we    <= w_wr;
         r_fft_start <= (r_state == START);
         r_col_adv   <= w_done_run;
         r_overrun   <= w_ovr;
         if (w_wr) begin
            r_buf_waddr <= {w_wr_bank, w_wr_idx};
            r_buf_wdata <= ADATA;
         end
         if (w_swap) begin
            r_pending   <= 1'b1;
            r_pend_bank <= w_wr_bank;
         end else if (r_state == START) begin
            r_pending   <= 1'b0;
         end
         if (r_state == START) begin
            r_fft_bank <= r_pend_bank;
         end
         if (w_done_run) begin
            r_frame_cnt <= r_frame_cnt + 16'h0001;
         end
      end
   end

`ifdef SCHED_OVERRUN_CNT_EN
   logic [7:0] r_ovr_cnt;

   // Dropped-frame count, saturating at full scale
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ovr_cnt <= 8'h00;
      end else if (w_ovr && (r_ovr_cnt != 8'hFF)) begin
         r_ovr_cnt <= r_ovr_cnt + 8'h01;
      end
   end

   assign ovr_cnt = r_ovr_cnt;
`endif

   assign buf_we    = r_buf_we;
   assign buf_waddr = r_buf_waddr;
   assign buf_wdata = r_buf_wdata;
   assign fft_start = r_fft_start;
   assign fft_bank  = r_fft_bank;
   assign col_adv   = r_col_adv;
   assign overrun   = r_overrun;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_spectro_frame_sched.sv
// Directed bench for spectro_frame_sched with 8-sample frames.
module tb_spectro_frame_sched;

   logic        CLK;
   logic        nRST;
   logic        EN;
   logic [17:0] ADATA;
   logic        ADATARDY;
   logic        buf_we;
   logic [3:0]  buf_waddr;
   logic [17:0] buf_wdata;
   logic        fft_start;
   logic        fft_bank;
   logic        fft_done;
   logic        col_adv;
   logic        overrun;
   logic [15:0] frame_cnt;
`ifdef SCHED_OVERRUN_CNT_EN
   logic [7:0]  ovr_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int n_ovr   = 0;
   int s0;
   int o0;

   spectro_frame_sched #(
      .DATA_W    (18),
      .FRAME_LEN (8),
      .ADDR_W    (3)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .EN        (EN),
      .ADATA     (ADATA),
      .ADATARDY  (ADATARDY),
      .buf_we    (buf_we),
      .buf_waddr (buf_waddr),
      .buf_wdata (buf_wdata),
      .fft_start (fft_start),
      .fft_bank  (fft_bank),
      .fft_done  (fft_done),
      .col_adv   (col_adv),
      .overrun   (overrun),
      .frame_cnt (frame_cnt)
`ifdef SCHED_OVERRUN_CNT_EN
      ,
      .ovr_cnt   (ovr_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Pulse tallies used to prove no spurious start/overrun
   always @(negedge CLK) begin
      if (fft_start === 1'b1) n_start++;
      if (overrun === 1'b1) n_ovr++;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"},    32'(buf_we),    32'd0);
      chk({tag, "_waddr"}, 32'(buf_waddr), 32'd0);
      chk({tag, "_wdata"}, 32'(buf_wdata), 32'd0);
      chk({tag, "_start"}, 32'(fft_start), 32'd0);
      chk({tag, "_bank"},  32'(fft_bank),  32'd0);
      chk({tag, "_coladv"},32'(col_adv),   32'd0);
      chk({tag, "_ovr"},   32'(overrun),   32'd0);
      chk({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
`ifdef SCHED_OVERRUN_CNT_EN
      chk({tag, "_ovrcnt"},32'(ovr_cnt),   32'd0);
`endif
   endtask

   // One accepted sample strobe, then check the registered write and overrun flag
   task automatic wr(input logic [17:0] data, input int exp_addr, input int exp_ovr,
                     input logic done, input int gap);
      ADATA    = data;
      ADATARDY = 1'b1;
      fft_done = done;
      tick();
      ADATARDY = 1'b0;
      fft_done = 1'b0;
      chk("we",    32'(buf_we),    32'd1);
      chk("waddr", 32'(buf_waddr), 32'(exp_addr));
      chk("wdata", 32'(buf_wdata), 32'(data));
      chk("ovr",   32'(overrun),   32'(exp_ovr));
      repeat (gap) tick();
   endtask

   initial begin
      nRST     = 1'b0;
      EN       = 1'b0;
      ADATA    = 18'h00000;
      ADATARDY = 1'b0;
      fft_done = 1'b0;
      repeat (3) tick();
      chk_all_zero("por");
      nRST = 1'b1;
      EN   = 1'b1;
      tick();

      // Fill bank 0 with the FFT idle
      for (int i = 0; i < 7; i++) wr(18'h10000 + 18'(i), i, 0, 1'b0, 2);
      wr(18'h10007, 7, 0, 1'b0, 0);
      chk("start_t1", 32'(fft_start), 32'd0);
      tick();
      chk("start_t2", 32'(fft_start), 32'd0);
      tick();
      chk("start_t3", 32'(fft_start), 32'd1);
      chk("bank_t3",  32'(fft_bank),  32'd0);

      // FFT completes 20 cycles after start
      repeat (20) tick();
      chk("start_pulse", 32'(fft_start), 32'd0);
      chk("coladv_pre",  32'(col_adv),   32'd0);
      chk("fcnt_pre",    32'(frame_cnt), 32'd0);
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      chk("coladv",  32'(col_adv),   32'd1);
      chk("fcnt_1",  32'(frame_cnt), 32'd1);
      tick();
      chk("coladv_pulse", 32'(col_adv), 32'd0);

      // Bank 1 fills and starts, then bank 0 fills with the FFT still busy
      for (int i = 0; i < 7; i++) wr(18'h20000 + 18'(i), 8 + i, 0, 1'b0, 2);
      wr(18'h20007, 15, 0, 1'b0, 0);
      tick();
      tick();
      chk("start_b1", 32'(fft_start), 32'd1);
      chk("bank_b1",  32'(fft_bank),  32'd1);
      for (int i = 0; i < 7; i++) wr(18'h30000 + 18'(i), i, 0, 1'b0, 2);
      wr(18'h30007, 7, 1, 1'b0, 0);
      chk("fcnt_ovr", 32'(frame_cnt), 32'd1);
`ifdef SCHED_OVERRUN_CNT_EN
      chk("ovrcnt_1", 32'(ovr_cnt), 32'd1);
`endif
      tick();
      chk("ovr_pulse", 32'(overrun), 32'd0);
      wr(18'h31000, 0, 0, 1'b0, 2);

      // FFT done coincides with the last sample of the refilled bank 0
      for (int i = 1; i < 7; i++) wr(18'h31000 + 18'(i), i, 0, 1'b0, 2);
      wr(18'h31007, 7, 0, 1'b1, 0);
      chk("coladv_sim", 32'(col_adv),   32'd1);
      chk("fcnt_2",     32'(frame_cnt), 32'd2);
      tick();
      chk("start_sim_t2", 32'(fft_start), 32'd0);
      tick();
      chk("start_sim_t3", 32'(fft_start), 32'd1);
      chk("bank_sim",     32'(fft_bank),  32'd0);
      repeat (5) tick();
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      chk("fcnt_3", 32'(frame_cnt), 32'd3);
      chk("ovr_total", 32'(n_ovr), 32'd1);

      // Partial frame abandoned by dropping EN
      s0 = n_start;
      o0 = n_ovr;
      for (int i = 0; i < 5; i++) wr(18'h40000 + 18'(i), 8 + i, 0, 1'b0, 2);
      EN = 1'b0;
      tick();
      ADATA    = 18'h3FFFF;
      ADATARDY = 1'b1;
      tick();
      ADATARDY = 1'b0;
      chk("we_en_off", 32'(buf_we), 32'd0);
      EN = 1'b1;
      tick();
      wr(18'h41000, 8, 0, 1'b0, 2);
      chk("partial_start", 32'(n_start - s0), 32'd0);
      chk("partial_ovr",   32'(n_ovr - o0),   32'd0);

      // Reset mid-frame
      wr(18'h41001, 9, 0, 1'b0, 0);
      nRST = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      tick();
      tick();
      nRST = 1'b1;
      tick();
      wr(18'h05A5A, 0, 0, 1'b0, 2);
      chk("fcnt_after_rst", 32'(frame_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
